// File: rtl/cpu_test_harness_ctrl_if.sv
// Bus bundle between the CPU test harness controller and its surroundings:
// the CPU data-memory write port plus the trace FIFO read port.
interface cpu_test_harness_ctrl_if #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TRACE_DEPTH = 16
);
    logic [DATA_W-1:0]              data_to_mem;
    logic [ADDR_W-1:0]              address_to_mem;
    logic                           write_enable;
    logic                           trace_rd_en;
    logic [ADDR_W+DATA_W-1:0]       trace_rd_data;
    logic                           trace_empty;
    logic [$clog2(TRACE_DEPTH):0]   trace_count;
    logic                           trace_overflow;

    modport master (
        output data_to_mem, address_to_mem, write_enable, trace_rd_en,
        input  trace_rd_data, trace_empty, trace_count, trace_overflow
    );

    modport slave (
        input  data_to_mem, address_to_mem, write_enable, trace_rd_en,
        output trace_rd_data, trace_empty, trace_count, trace_overflow
    );
endinterface

// File: rtl/cpu_test_harness_ctrl.sv
// Run controller for the single-cycle CPU under test: reset sequencing, cycle
// counting, mailbox/timeout detection and a FWFT trace FIFO of memory writes.
// Optional address filter on traced writes: define HARNESS_TRACE_FILTER_EN.
module cpu_test_harness_ctrl #(
    parameter int                 DATA_W         = 32,
    parameter int                 ADDR_W         = 32,
    parameter int                 TRACE_DEPTH    = 16,
    parameter int                 RST_CYCLES     = 2,
    parameter int                 TIMEOUT_CYCLES = 50,
    parameter logic [ADDR_W-1:0]  DONE_ADDR      = 32'h000000FC,
    parameter logic [DATA_W-1:0]  PASS_VALUE     = 32'h00000001
`ifdef HARNESS_TRACE_FILTER_EN
    ,
    parameter logic [ADDR_W-1:0]  FILT_LO        = '0,
    parameter logic [ADDR_W-1:0]  FILT_HI        = 32'h000000FF
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    cpu_test_harness_ctrl_if.slave        bus,
    output logic                          cpu_reset,
    output logic [1:0]                    state,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [31:0]                   cycle_count
);

    localparam int PTR_W   = $clog2(TRACE_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int RC_W    = $clog2(RST_CYCLES + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESET_CPU = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [RC_W-1:0]    rst_cnt;
    logic [ENTRY_W-1:0] mem [TRACE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               overflow_q;

    logic restart, in_run, mailbox_hit, timeout_hit, rst_done;
    logic trace_sel, push_req, fifo_full, do_pop, do_push;

    // A restart is only honoured from IDLE or DONE; start is ignored elsewhere.
    assign restart     = start && (state_q == IDLE || state_q == DONE);
    assign in_run      = (state_q == RUN);
    assign mailbox_hit = in_run && bus.write_enable && (bus.address_to_mem == DONE_ADDR);
    assign timeout_hit = in_run && !mailbox_hit && (cycle_count == 32'(TIMEOUT_CYCLES - 1));
    assign rst_done    = (rst_cnt == RC_W'(RST_CYCLES - 1));

`ifdef HARNESS_TRACE_FILTER_EN
    assign trace_sel = mailbox_hit ||
                       ((bus.address_to_mem >= FILT_LO) && (bus.address_to_mem <= FILT_HI));
`else
    assign trace_sel = 1'b1;
`endif

    // Pushing into a full FIFO succeeds only when a pop frees the head slot.
    assign push_req  = in_run && bus.write_enable && trace_sel;
    assign fifo_full = (fifo_cnt == CNT_W'(TRACE_DEPTH));
    assign do_pop    = bus.trace_rd_en && (fifo_cnt != '0);
    assign do_push   = push_req && (!fifo_full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start)                      state_d = RESET_CPU;
            RESET_CPU: if (rst_done)                   state_d = RUN;
            RUN:       if (mailbox_hit || timeout_hit) state_d = DONE;
            DONE:      if (start)                      state_d = RESET_CPU;
            default:                                   state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_reset = (state_q != RUN);
        state     = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    rst_cnt <= '0;
        else if (state_q == RESET_CPU) rst_cnt <= rst_cnt + 1'b1;
        else                          rst_cnt <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (restart) begin
            cycle_count <= '0;
        end else if (in_run && cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // A mailbox write in the timeout cycle wins, so timeout_hit excludes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (restart) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (mailbox_hit) begin
            done    <= 1'b1;
            pass    <= (bus.data_to_mem == PASS_VALUE);
            timeout <= 1'b0;
        end else if (timeout_hit) begin
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (restart) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_req && fifo_full && !do_pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {bus.address_to_mem, bus.data_to_mem};
    end

    assign bus.trace_rd_data  = (fifo_cnt == '0) ? '0 : mem[rd_ptr];
    assign bus.trace_empty    = (fifo_cnt == '0);
    assign bus.trace_count    = fifo_cnt;
    assign bus.trace_overflow = overflow_q;

endmodule

// File: doc/cpu_test_harness_ctrl.md
Name: cpu_test_harness_ctrl

Overview:
Synthesizable run controller for the single-cycle CPU system under test. It sequences the CPU reset, counts run cycles, and records every data-memory write into a trace FIFO. It detects end-of-test, a write to a mailbox address, and flags pass, fail or timeout. It replaces the fixed-delay sequencing used so far, so benches and FPGA wrappers can run variable-length programs and inspect the write history.

Parameters:
DATA_W, 32, width of data_to_mem
ADDR_W, 32, width of address_to_mem
TRACE_DEPTH, 16, trace FIFO entries (power of two, >=2)
RST_CYCLES, 2, cycles cpu_reset is held in RESET_CPU (>=1)
TIMEOUT_CYCLES, 50, RUN cycles before timeout (>=1)
DONE_ADDR, 32'h000000FC, mailbox address that ends the test
PASS_VALUE, 32'h00000001, mailbox data meaning pass

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle start/restart request
data_to_mem  in  DATA_W  CPU write data
address_to_mem  in  ADDR_W  CPU write address
write_enable  in  1  CPU memory write strobe
cpu_reset  out  1  reset to the CPU
state  out  2  0=IDLE 1=RESET_CPU 2=RUN 3=DONE
done  out  1  test finished, pass or timeout valid
pass  out  1  mailbox data equalled PASS_VALUE
timeout  out  1  TIMEOUT_CYCLES elapsed without a mailbox write
cycle_count  out  32  RUN cycles elapsed
trace_rd_en  in  1  pop trace head
trace_rd_data  out  ADDR_W+DATA_W  head entry {addr,data}
trace_empty  out  1  FIFO empty
trace_count  out  $clog2(TRACE_DEPTH)+1  entries held
trace_overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset is asynchronous and active-high. It forces: state=IDLE, cpu_reset=1, done=0, pass=0, timeout=0, cycle_count=0, FIFO empty, trace_overflow=0.
- IDLE: cpu_reset=1. start=1 -> RESET_CPU and clears counters, flags and FIFO.
- RESET_CPU: cpu_reset=1 for exactly RST_CYCLES cycles, counted from the first RESET_CPU cycle, then -> RUN.
- RUN: cpu_reset=0.
  - cycle_count increments by 1 every RUN cycle. The first RUN cycle reads 0 and becomes 1 after that cycle's edge.
  - The counter saturates at 2^32-1.
  - start is ignored while in RUN.
- Trace capture: in RUN, write_enable=1 pushes {address_to_mem,data_to_mem} at the clock edge. Writes outside RUN are ignored.
- Mailbox write (write_enable && address_to_mem==DONE_ADDR) in RUN:
  - The write is traced.
  - pass <= (data_to_mem==PASS_VALUE).
  - done <= 1.
  - Next state DONE.
- Timeout: when a RUN cycle has no mailbox write and the increment would make cycle_count==TIMEOUT_CYCLES:
  - timeout <= 1, done <= 1, pass <= 0.
  - Next state DONE.
- Mailbox write and timeout in the same cycle: the mailbox wins. pass is evaluated and timeout stays 0.
- DONE: cpu_reset=1, freezing the CPU. Flags and cycle_count hold. start=1 -> RESET_CPU with a full clear, including the FIFO.
- FIFO is first-word fall-through:
  - trace_rd_data shows the head combinationally; it is 0 when empty.
  - trace_rd_en pops at the edge when not empty. Pop on empty is ignored with no error.
  - Reads are legal in every state.
- Full FIFO:
  - A push without a simultaneous pop is dropped and sets trace_overflow, which is sticky until restart or reset.
  - Push and pop together while full: both occur, count is unchanged, no overflow.
  - Push and pop together while empty: only the push is effective, count becomes 1.
- Pointers wrap modulo TRACE_DEPTH. trace_count is the exact occupancy 0..TRACE_DEPTH.
- Reset asserted mid-RUN: immediate return to IDLE with all state cleared, including the FIFO.

Optional Feature:
HARNESS_TRACE_FILTER_EN
- Defined: adds parameters FILT_LO (default 0) and FILT_HI (default 32'h000000FF). Only writes with FILT_LO<=address_to_mem<=FILT_HI are pushed. The mailbox write is always pushed. Mailbox detection and timeout are unaffected.
- Undefined: every RUN write is pushed, and the FILT parameters do not exist.

Test Plan:
1. Reset, then start. -> cpu_reset stays 1 for exactly 2 cycles after start, then drops; state goes 1 then 2; cycle_count starts at 0.
2. In RUN, writes (0x10,0xA), (0x14,0xB), then (0xFC,0x1). -> done=1, pass=1, timeout=0, state=3, trace_count=3; pops return {0x10,0xA}, {0x14,0xB}, {0xFC,0x1}; trace_empty=1 afterwards.
3. Mailbox write (0xFC,0x5). -> done=1, pass=0, timeout=0.
4. No mailbox write for 50 RUN cycles. -> timeout=1, done=1, pass=0, cycle_count=50, cpu_reset=1. Variant: mailbox write on the 50th cycle -> pass evaluated, timeout=0.
5. 18 writes with no pops (depth 16). -> trace_count=16, trace_overflow=1, head is the first write. Variant: 17th write issued together with a pop -> trace_count stays 16 and the overflow flag is unaffected by that cycle.
6. Reset pulse mid-RUN after 5 writes. -> state=0, trace_empty=1, cycle_count=0, cpu_reset=1 immediately; start from DONE likewise clears all flags.
